// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream into 128-bit lines and writes them to imem from line 0; optional checksum via IMEM_LOADER_CHECKSUM_EN.
// Latency: 16th byte of a line accepted at edge N gives imem_we in cycle N+1; min 17 cycles per line.
// Backpressure: in_ready is high only in FILL, so bytes stall during the WRITE cycle and in IDLE/DONE.
module imem_loader #(
    parameter int NUM_LINES = 512
) (
    input  logic         clk,
    input  logic         reset_x,
    input  logic         start,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [8:0]   imem_addr,
    output logic [127:0] imem_wdata,
    output logic         imem_we,
    output logic         busy,
    output logic         done,
    output logic [9:0]   line_cnt,
    output logic [31:0]  checksum
);

    localparam int INSN_LEN = 32;
    localparam logic [10:0] NUM_LINES_W = 11'(NUM_LINES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic [3:0]              byte_idx;
    logic [4*INSN_LEN-1:0]   line_buf;
    logic                    accept;
    logic                    start_fire;
    logic                    more_lines;

    // in_ready is a registered decode of FILL, so it doubles as the state qualifier here.
    assign accept     = in_valid & in_ready;
    assign start_fire = start & ((state == IDLE) | (state == DONE));
    assign more_lines = ({1'b0, line_cnt} + 11'd1) < NUM_LINES_W;

    // The line buffer only reaches memory after all 16 bytes have landed, so it is the write data directly.
    assign imem_wdata = line_buf;
    assign imem_addr  = line_cnt[8:0];

    always_ff @(posedge clk) begin
        if (!reset_x) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            imem_we  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            byte_idx <= 4'd0;
            line_buf <= '0;
            line_cnt <= 10'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_fire) begin
                        state    <= FILL;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        byte_idx <= 4'd0;
                        line_cnt <= 10'd0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        line_buf[{byte_idx, 3'b000} +: 8] <= in_data;
                        byte_idx <= byte_idx + 4'd1;
                        if (byte_idx == 4'd15) begin
                            state    <= WRITE;
                            in_ready <= 1'b0;
                            imem_we  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    imem_we  <= 1'b0;
                    line_cnt <= line_cnt + 10'd1;
                    if (more_lines) begin
                        state    <= FILL;
                        in_ready <= 1'b1;
                    end else begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    imem_we  <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk) begin
        if (!reset_x) begin
            sum_q <= 32'd0;
        end else if (start_fire) begin
            sum_q <= 32'd0;
        end else if (accept) begin
            sum_q <= sum_q + {24'd0, in_data};
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (NUM_LINES=2): expected line writes go into a scoreboard queue,
// a negedge monitor pops and compares every imem_we cycle.
module tb_imem_loader;

    logic         clk = 1'b0;
    logic         reset_x;
    logic         start;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [8:0]   imem_addr;
    logic [127:0] imem_wdata;
    logic         imem_we;
    logic         busy;
    logic         done;
    logic [9:0]   line_cnt;
    logic [31:0]  checksum;

    always #5 clk = ~clk;

    imem_loader #(.NUM_LINES(2)) dut (
        .clk        (clk),
        .reset_x    (reset_x),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_we    (imem_we),
        .busy       (busy),
        .done       (done),
        .line_cnt   (line_cnt),
        .checksum   (checksum)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef struct {
        logic [8:0]   addr;
        logic [127:0] data;
        bit           last;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    bit   post_wr   = 1'b0;
    bit   post_last = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    localparam logic [127:0] LINE_LO = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] LINE_HI = 128'h1F1E1D1C1B1A19181716151413121110;
    localparam logic [127:0] LINE_AA = {16{8'hAA}};
    localparam logic [127:0] LINE_55 = {16{8'h55}};
    localparam logic [127:0] LINE_FF = {16{8'hFF}};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [8:0] addr, input logic [127:0] data, input bit last);
        wr_t e;
        e.addr = addr;
        e.data = data;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every write against the scoreboard and checks the cycle after it.
    initial begin
        forever begin
            @(negedge clk);
            if (post_wr) begin
                check("done_after_write", done, post_last);
                if (post_last) check("line_cnt_at_done", line_cnt, 10'd2);
                else           check("ready_after_write", in_ready, 1'b1);
                post_wr = 1'b0;
            end
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected",
                             imem_addr, imem_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_addr", imem_addr, mon_e.addr);
                    check("write_data", imem_wdata, mon_e.data);
                    check("ready_in_write", in_ready, 1'b0);
                    if (!CSUM_EN) check("checksum_tied", checksum, 32'd0);
                    post_wr   = 1'b1;
                    post_last = mon_e.last;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got = 1'b0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        if (!got) check("in_ready_timeout", got, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = done;
        end
        check("done_timeout", got, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        reset_x  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) begin
            start    = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_imem_we", imem_we, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_imem_addr", imem_addr, 9'd0);
        check("rst_imem_wdata", imem_wdata, 128'd0);
        check("rst_line_cnt", line_cnt, 10'd0);
        check("rst_checksum", checksum, 32'd0);
        start    = 1'b0;
        in_valid = 1'b0;
        reset_x  = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", busy, 1'b0);

        // Continuous two-line load 0x00..0x1F.
        push_wr(9'd0, LINE_LO, 1'b0);
        push_wr(9'd1, LINE_HI, 1'b1);
        pulse_start();
        check("start_in_ready", in_ready, 1'b1);
        check("start_busy", busy, 1'b1);
        for (int k = 0; k < 32; k++) send_byte(8'(k), 0);
        in_valid = 1'b0;
        wait_done();
        check("cont_checksum", checksum, CSUM_EN ? 32'h1F0 : 32'h0);
        check("cont_busy_done", busy, 1'b0);
        check("cont_queue_empty", 128'(exp_q.size()), 128'd0);

        // Bytes offered in DONE must not be consumed.
        in_data  = 8'h77;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("done_in_ready", in_ready, 1'b0);
        check("done_line_cnt_held", line_cnt, 10'd2);

        // Restart from DONE with stalls and ignored start pulses.
        push_wr(9'd0, LINE_LO, 1'b0);
        push_wr(9'd1, LINE_HI, 1'b1);
        pulse_start();
        check("restart_done", done, 1'b0);
        check("restart_line_cnt", line_cnt, 10'd0);
        check("restart_in_ready", in_ready, 1'b1);
        for (int k = 0; k < 32; k++) begin
            send_byte(8'(k), (k * 5 + 3) % 4);
            if (k == 4) begin
                pulse_start();
                check("fill_start_busy", busy, 1'b1);
                check("fill_start_line_cnt", line_cnt, 10'd0);
            end
            if (k == 20) begin
                pulse_start();
                check("fill2_start_line_cnt", line_cnt, 10'd1);
            end
        end
        in_valid = 1'b0;
        wait_done();
        check("stall_checksum", checksum, CSUM_EN ? 32'h1F0 : 32'h0);
        check("stall_queue_empty", 128'(exp_q.size()), 128'd0);

        // Reset in the middle of a line discards the partial bytes.
        pulse_start();
        for (int k = 0; k < 9; k++) send_byte(8'h30 + 8'(k), 0);
        in_valid = 1'b0;
        reset_x  = 1'b0;
        @(posedge clk); #1;
        reset_x  = 1'b1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_line_cnt", line_cnt, 10'd0);
        check("midrst_checksum", checksum, 32'd0);
        push_wr(9'd0, LINE_AA, 1'b0);
        push_wr(9'd1, LINE_55, 1'b1);
        pulse_start();
        for (int k = 0; k < 16; k++) send_byte(8'hAA, 0);
        for (int k = 0; k < 16; k++) send_byte(8'h55, 0);
        in_valid = 1'b0;
        wait_done();
        check("midrst_final_checksum", checksum, CSUM_EN ? 32'hFF0 : 32'h0);
        check("midrst_queue_empty", 128'(exp_q.size()), 128'd0);

        // 32 bytes of 0xFF.
        push_wr(9'd0, LINE_FF, 1'b0);
        push_wr(9'd1, LINE_FF, 1'b1);
        pulse_start();
        for (int k = 0; k < 32; k++) send_byte(8'hFF, k % 2);
        in_valid = 1'b0;
        wait_done();
        check("ff_checksum", checksum, CSUM_EN ? 32'h1FE0 : 32'h0);
        check("ff_queue_empty", 128'(exp_q.size()), 128'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader that fills the 4-way instruction memory (128-bit lines, 512 deep) from a byte stream such as a UART receiver. It packs 16 incoming bytes into one line and drives the write port of the loadable instruction memory, one line per write, starting at line 0. When the programmed number of lines has been written it raises `done`, which holds the core in reset until the image is complete.

## Interface

Parameters:

- `NUM_LINES`, default 512: lines to load per image; legal range 1..512.

Ports. One clock; reset is synchronous and active-low.

- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `reset_x` input, 1 bit: synchronous, active-low reset.
- `start` input, 1 bit: begin a load; sampled only in IDLE or DONE.
- `in_data` input, 8 bits: stream byte.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_ready` output, 1 bit: loader accepts a byte this cycle.
- `imem_addr` output, 9 bits: line address to the instruction memory write port.
- `imem_wdata` output, 4*`INSN_LEN` (128) bits: line data.
- `imem_we` output, 1 bit: write enable, one cycle per line.
- `busy` output, 1 bit: state is FILL or WRITE.
- `done` output, 1 bit: image fully written.
- `line_cnt` output, 10 bits: lines written since last `start`.
- `checksum` output, 32 bits: running byte sum; see Configuration.

## Operation

- States:
  - IDLE (reset state).
  - FILL: `in_ready`=1. A byte is accepted in any cycle with `in_valid`&`in_ready`.
  - WRITE: exactly one cycle; `in_ready`=0, `imem_we`=1.
  - DONE: `done`=1.
- Transitions:
  - IDLE or DONE, with `start`=1 → FILL. Clears byte counter, `line_cnt` and `checksum`.
  - FILL → WRITE on acceptance of the 16th byte of a line (byte counter 15).
  - WRITE → FILL when `line_cnt`+1 < `NUM_LINES`; otherwise → DONE.
- Packing: byte k of a line (k=0..15, arrival order) lands in `imem_wdata[8k+7:8k]`.
  - Little-endian instructions; instruction 0 occupies bits [31:0].
- Line buffer: a 128-bit register written per byte at the current byte index. Stale upper bytes are never visible because a write only occurs after all 16 bytes arrive.
- During WRITE:
  - `imem_addr` = `line_cnt[8:0]`, `imem_wdata` = line buffer.
  - `line_cnt` increments at the end of the WRITE cycle.
- Outside WRITE, `imem_we`=0. `imem_addr` and `imem_wdata` hold their last values and are don't-care.
- `start` while `busy` is ignored.
- `in_valid` outside FILL is ignored; no byte is consumed because `in_ready`=0.

## Timing

- Reset values (reset_x=0 at a clock edge):
  - State IDLE; `in_ready`, `imem_we`, `busy`, `done` = 0.
  - `imem_addr`=0, `imem_wdata`=0, `line_cnt`=0, `checksum`=0.
  - Byte counter = 0.
- Reset mid-operation: the partial line is discarded and no write is issued in or after the reset cycle. The loader returns to IDLE.
- `in_ready` is a registered state decode: high from the cycle after `start` is sampled.
- Line write:
  - 16th byte accepted at edge N; `imem_we`=1 during cycle N+1.
  - Byte acceptance resumes in cycle N+2.
  - Minimum 17 cycles per line with a continuous stream.
- `done` rises the cycle after the final WRITE cycle and holds until `start` or reset.
- The memory write takes effect at the edge ending the WRITE cycle. Readback of that line is valid one cycle later (synchronous read port).
- `line_cnt` saturates at `NUM_LINES`; it never wraps because DONE blocks further writes.

## Configuration

- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - `checksum` is a 32-bit wrapping sum of every accepted byte (zero-extended).
  - Updated on the accept edge; cleared on `start` and reset.
  - Final value is stable when `done` rises.
- Not defined: `checksum` is tied to 0 and no adder is synthesized. The port remains present.

## Test plan

- Reset: hold reset_x=0 for 3 cycles with random inputs → all outputs 0, state IDLE, `in_ready`=0.
- Two-line load, `NUM_LINES`=2, continuous bytes 0x00..0x1F:
  - `imem_we` pulses twice, at addr 0 then 1.
  - Line 0 `imem_wdata` = 0x0F0E...0100; line 1 = 0x1F1E...1110.
  - `done`=1 exactly one cycle after the second write; `line_cnt`=2.
- Stall handling: `in_valid` toggled pseudo-randomly → same write data and addresses as the continuous case; `in_ready`=0 in each WRITE cycle.
- Reset mid-line: after 9 bytes, reset_x=0 for one cycle, then `start` and 16 bytes 0xAA:
  - Single write to addr 0 with data all 0xAA.
  - No write carries earlier bytes.
- Restart and ignored start:
  - `start` pulsed during FILL → no effect.
  - `start` in DONE → `done` drops, `line_cnt`=0, reload begins at addr 0.
- Checksum (macro defined): 32 bytes of 0xFF → `checksum`=0x00001FE0 at `done`. Macro undefined → `checksum`=0 throughout.
